dex_scoreboard: RTL and testbench
=================================

# dex_scoreboard

Parametrised register scoreboard for the decode/execute stage. It generates the pipeline STALL that the fixed two-writeback-port decode/execute block currently derives ad hoc. It tracks outstanding writes per architectural register, with up to MAX_OUT in flight per register. It also locks the VPU register window (V0–V7, RO) between VPU start and VPU ready. It sits beside the register file: decode presents the candidate instruction's operands, and memory/write-back reports retiring writes.

## Interface
- NUM_REGS, 32: tracked architectural registers.
- ADDR_W, 5: register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- NUM_SRC, 2: source operand ports.
- NUM_DST, 2: destination ports per issue.
- NUM_WB, 2: write-back retire ports.
- MAX_OUT, 3: maximum outstanding writes per register (1..7).
- VPU_BASE, 16: first address of the VPU window.
- VPU_REGS, 9: size of the VPU window.
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- src_valid  in  NUM_SRC  per-source operand valid.
- src_addr  in  NUM_SRC×ADDR_W  source addresses.
- dst_valid  in  NUM_DST  per-destination valid.
- dst_addr  in  NUM_DST×ADDR_W  destination addresses.
- vpu_start  in  1  instruction launches the VPU.
- vpu_rdy  in  1  one-cycle pulse: VPU finished; its results are written.
- wb_valid  in  NUM_WB  retire strobe per write-back port.
- wb_addr  in  NUM_WB×ADDR_W  retiring register address.
- stall  out  1  combinational; the instruction must be held.
- issue_ack  out  1  combinational; equals issue_valid & ~stall.
- pending  out  NUM_REGS  registered; bit r is 1 when count[r] != 0.
- vpu_lock  out  1  registered; VPU window locked.
- busy  out  1  registered; any pending bit set or vpu_lock.
- err_underflow  out  1  registered, sticky; a retire arrived for a register with count 0.

## Operation
- State per register: count[r], width clog2(MAX_OUT+1). Plus vpu_lock and err_underflow.
- `stall` asserts when issue_valid=1 and any of the following holds:
  - a valid src has count != 0 (RAW hazard);
  - a valid dst has count == MAX_OUT (saturation);
  - vpu_lock=1 and any valid src or dst lies in [VPU_BASE, VPU_BASE+VPU_REGS);
  - vpu_lock=1 and vpu_start=1.
- Out-of-range addresses (>= NUM_REGS) are ignored for hazard checks and counting.
- WAW hazards below saturation do not stall; retire order per register is the write-back's responsibility.
- On accepted issue (issue_ack), count[d] increments by 1 for each distinct valid dst. Two dst ports carrying the same address increment once.
- On wb_valid[k], count[wb_addr[k]] decrements by 1. Multiple ports naming the same register decrement once per port.
- Each cycle, the net update is count + inc − dec, applied once.
- If a decrement would go below 0, the result clamps at 0 and err_underflow sets; only rst clears it.
- vpu_lock:
  - sets on issue_ack & vpu_start;
  - clears on vpu_rdy;
  - if both occur in the same cycle, it stays set (the new launch wins).
  - vpu_rdy while unlocked has no effect.
- Reset (rst=1 at a clock edge): all counts 0, vpu_lock 0, err_underflow 0. This also applies mid-operation, discarding outstanding state.
  - Outputs after reset: pending 0, busy 0, vpu_lock 0, err_underflow 0.
  - stall and issue_ack follow their equations; stall is 0 after reset because no hazards remain.

## Timing
- No bypass: stall uses the registered counts and lock only. A retire in cycle N unblocks a dependent issue in cycle N+1.
- An issue accepted in cycle N makes its dst pending from cycle N+1.
- Issue and retire on the same register in the same cycle leave the count unchanged.
- Handshake: decode holds issue_valid and the operand fields stable while stall=1. The scoreboard itself holds no instruction state.

## Structure
- Shared package dex_pkg:
  - the count type and the clog2-based count width;
  - an in_vpu_window function.
- Sub-module dex_sb_counter, instantiated NUM_REGS times:
  - inputs: inc, dec_n (0..NUM_WB), sat;
  - outputs: count, nonzero, underflow.
- The top level performs dst deduplication, hazard reduction and the vpu_lock flop.

## Test plan
- RAW: issue dst=r5 → cycle+1 pending[5]=1; issue src=r5 gives stall=1; wb r5 → next cycle stall=0 and issue_ack=1.
- Saturation, MAX_OUT=3:
  - three issues with dst=r7 are accepted;
  - the fourth stalls;
  - one wb r7 brings count to 2 and the fourth issue is accepted.
- Same cycle: issue dst=r3 together with wb r3, starting from count 1 → count stays 1. Dual wb r3 on both ports from count 2 → count 0.
- VPU lock:
  - issue with vpu_start → vpu_lock=1;
  - src=r17 stalls, src=r2 does not;
  - a second vpu_start stalls;
  - vpu_rdy → next cycle both accepted.
- Underflow: wb r9 at count 0 → err_underflow=1 and stays 1; count stays 0.
- Reset: with counts nonzero and vpu_lock=1, assert rst for one cycle → all outputs 0 and a stalled src is accepted on the next issue.

Source files
------------

// File: rtl/dex_pkg.sv
// Shared types and helpers for the decode/execute register scoreboard.
// Counter width covers the largest supported MAX_OUT so every configuration shares one type.
package dex_pkg;

    localparam int MAX_OUT_LIMIT = 7;
    localparam int CNT_W         = $clog2(MAX_OUT_LIMIT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic in_vpu_window(input int addr, input int base, input int size);
        return (addr >= base) && (addr < base + size);
    endfunction

endpackage

// File: rtl/dex_sb_counter.sv
// Outstanding-write counter for one architectural register.
// Applies the net update count + inc - dec_n once per cycle, clamping at 0 and at sat.
module dex_sb_counter
    import dex_pkg::*;
#(
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec_n,
    input  cnt_t             sat,
    output cnt_t             count,
    output logic             nonzero,
    output logic             underflow
);

    cnt_t count_q;
    cnt_t count_d;
    int   next_val;

    always_comb begin
        next_val  = int'(count_q) + (inc ? 1 : 0) - int'(dec_n);
        underflow = 1'b0;
        count_d   = count_q;
        if (next_val < 0) begin
            underflow = 1'b1;
            count_d   = '0;
        end else if (next_val > int'(sat)) begin
            count_d = sat;
        end else begin
            count_d = cnt_t'(next_val);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);

endmodule

// File: rtl/dex_scoreboard.sv
// Register scoreboard: per-register outstanding-write counts plus a VPU window lock.
// stall/issue_ack look only at registered state; there is no bypass from same-cycle retires.
module dex_scoreboard
    import dex_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_SRC  = 2,
    parameter int NUM_DST  = 2,
    parameter int NUM_WB   = 2,
    parameter int MAX_OUT  = 3,
    parameter int VPU_BASE = 16,
    parameter int VPU_REGS = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
    input  logic [NUM_DST-1:0]        dst_valid,
    input  logic [NUM_DST*ADDR_W-1:0] dst_addr,
    input  logic                      vpu_start,
    input  logic                      vpu_rdy,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*ADDR_W-1:0]  wb_addr,
    output logic                      stall,
    output logic                      issue_ack,
    output logic [NUM_REGS-1:0]       pending,
    output logic                      vpu_lock,
    output logic                      busy,
    output logic                      err_underflow
);

    localparam int   DEC_W = $clog2(NUM_WB + 1);
    localparam cnt_t SAT   = cnt_t'(MAX_OUT);

    cnt_t              count     [NUM_REGS];
    logic [DEC_W-1:0]  dec_cnt   [NUM_REGS];
    logic [NUM_REGS-1:0] nonzero;
    logic [NUM_REGS-1:0] underflow;
    logic [NUM_REGS-1:0] inc_vec;

    logic vpu_lock_q, vpu_lock_d;
    logic err_q, err_d;
    logic raw_hit, sat_hit, win_hit;
    logic [ADDR_W-1:0] a;

    // Hazard reduction; addresses outside the tracked range never match a register.
    always_comb begin
        raw_hit = 1'b0;
        sat_hit = 1'b0;
        win_hit = 1'b0;
        a       = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            a = src_addr[s*ADDR_W +: ADDR_W];
            if (src_valid[s] && int'(a) < NUM_REGS && in_vpu_window(int'(a), VPU_BASE, VPU_REGS))
                win_hit = 1'b1;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (src_valid[s] && a == ADDR_W'(r) && nonzero[r])
                    raw_hit = 1'b1;
            end
        end
        for (int d = 0; d < NUM_DST; d++) begin
            a = dst_addr[d*ADDR_W +: ADDR_W];
            if (dst_valid[d] && int'(a) < NUM_REGS && in_vpu_window(int'(a), VPU_BASE, VPU_REGS))
                win_hit = 1'b1;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (dst_valid[d] && a == ADDR_W'(r) && count[r] == SAT)
                    sat_hit = 1'b1;
            end
        end
        stall = issue_valid & (raw_hit | sat_hit | (vpu_lock_q & (win_hit | vpu_start)));
    end

    assign issue_ack = issue_valid & ~stall;

    // Duplicate destinations OR together so a register increments at most once per issue.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = 1'b0;
            dec_cnt[r] = '0;
            for (int d = 0; d < NUM_DST; d++) begin
                if (issue_ack && dst_valid[d] && dst_addr[d*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    inc_vec[r] = 1'b1;
            end
            for (int k = 0; k < NUM_WB; k++) begin
                if (wb_valid[k] && wb_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    dec_cnt[r] = dec_cnt[r] + DEC_W'(1);
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        dex_sb_counter #(
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[r]),
            .dec_n     (dec_cnt[r]),
            .sat       (SAT),
            .count     (count[r]),
            .nonzero   (nonzero[r]),
            .underflow (underflow[r])
        );
    end

    // A new launch in the same cycle as the finish keeps the window locked.
    always_comb begin
        vpu_lock_d = vpu_lock_q;
        if (issue_ack && vpu_start)
            vpu_lock_d = 1'b1;
        else if (vpu_rdy)
            vpu_lock_d = 1'b0;
        err_d = err_q | (|underflow);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpu_lock_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vpu_lock_q <= vpu_lock_d;
            err_q      <= err_d;
        end
    end

    assign pending       = nonzero;
    assign vpu_lock      = vpu_lock_q;
    assign busy          = (|nonzero) | vpu_lock_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_dex_scoreboard.sv
// Directed bench for dex_scoreboard: each vector pushes its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_dex_scoreboard;

    localparam int W = 37;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [1:0]  src_valid;
    logic [9:0]  src_addr;
    logic [1:0]  dst_valid;
    logic [9:0]  dst_addr;
    logic        vpu_start;
    logic        vpu_rdy;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_addr;
    logic        stall;
    logic        issue_ack;
    logic [31:0] pending;
    logic        vpu_lock;
    logic        busy;
    logic        err_underflow;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    logic         vec_valid = 1'b0;
    int           checks   = 0;
    int           failures = 0;

    dex_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .src_valid     (src_valid),
        .src_addr      (src_addr),
        .dst_valid     (dst_valid),
        .dst_addr      (dst_addr),
        .vpu_start     (vpu_start),
        .vpu_rdy       (vpu_rdy),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .stall         (stall),
        .issue_ack     (issue_ack),
        .pending       (pending),
        .vpu_lock      (vpu_lock),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    task automatic clr();
        rst         = 1'b0;
        issue_valid = 1'b0;
        src_valid   = '0;
        src_addr    = '0;
        dst_valid   = '0;
        dst_addr    = '0;
        vpu_start   = 1'b0;
        vpu_rdy     = 1'b0;
        wb_valid    = '0;
        wb_addr     = '0;
    endtask

    task automatic src0(input int a);
        src_valid[0] = 1'b1;
        src_addr[4:0] = 5'(a);
    endtask

    task automatic dst0(input int a);
        dst_valid[0] = 1'b1;
        dst_addr[4:0] = 5'(a);
    endtask

    task automatic dst1(input int a);
        dst_valid[1] = 1'b1;
        dst_addr[9:5] = 5'(a);
    endtask

    task automatic wb0(input int a);
        wb_valid[0] = 1'b1;
        wb_addr[4:0] = 5'(a);
    endtask

    task automatic wb1(input int a);
        wb_valid[1] = 1'b1;
        wb_addr[9:5] = 5'(a);
    endtask

    // Inputs are already driven; queue the expectation and hold for one cycle.
    task automatic push(input string nm, input logic e_stall, input logic e_ack,
                        input logic e_lock, input logic e_busy, input logic e_err,
                        input logic [31:0] e_pend);
        exp_q.push_back({e_stall, e_ack, e_lock, e_busy, e_err, e_pend});
        name_q.push_back(nm);
        vec_valid = 1'b1;
        @(posedge clk);
        #1;
        vec_valid = 1'b0;
        clr();
    endtask

    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        string        nm;
        if (vec_valid) begin
            act = {stall, issue_ack, vpu_lock, busy, err_underflow, pending};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL monitor: output with no expectation, got %h", act);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (act !== exp) begin
                    failures++;
                    $display("FAIL %s: got stall=%b ack=%b lock=%b busy=%b err=%b pend=%h, expected stall=%b ack=%b lock=%b busy=%b err=%b pend=%h",
                             nm, act[36], act[35], act[34], act[33], act[32], act[31:0],
                             exp[36], exp[35], exp[34], exp[33], exp[32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        clr();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr();

        push("reset_state", 0, 0, 0, 0, 0, 32'h0);

        // RAW on r5
        issue_valid = 1; dst0(5);          push("raw_issue_dst5", 0, 1, 0, 0, 0, 32'h0);
        issue_valid = 1; src0(5);          push("raw_stall",      1, 0, 0, 1, 0, bit_of(5));
        issue_valid = 1; src0(5); wb0(5);  push("raw_wb_no_bypass", 1, 0, 0, 1, 0, bit_of(5));
        issue_valid = 1; src0(5);          push("raw_released",   0, 1, 0, 0, 0, 32'h0);

        // Saturation on r7
        issue_valid = 1; dst0(7);          push("sat_issue1", 0, 1, 0, 0, 0, 32'h0);
        issue_valid = 1; dst0(7);          push("sat_issue2", 0, 1, 0, 1, 0, bit_of(7));
        issue_valid = 1; dst0(7);          push("sat_issue3", 0, 1, 0, 1, 0, bit_of(7));
        issue_valid = 1; dst0(7);          push("sat_fourth_stall", 1, 0, 0, 1, 0, bit_of(7));
        issue_valid = 1; dst0(7); wb0(7);  push("sat_wb_same_cycle", 1, 0, 0, 1, 0, bit_of(7));
        issue_valid = 1; dst0(7);          push("sat_fourth_accept", 0, 1, 0, 1, 0, bit_of(7));
        wb0(7); wb1(7);                    push("sat_dual_wb", 0, 0, 0, 1, 0, bit_of(7));
        wb0(7);                            push("sat_last_wb", 0, 0, 0, 1, 0, bit_of(7));

        // Same-cycle issue/retire, dst dedup, dual retire on r3
        issue_valid = 1; dst0(3);          push("same_issue_r3", 0, 1, 0, 0, 0, 32'h0);
        issue_valid = 1; dst0(3); wb0(3);  push("same_issue_wb_r3", 0, 1, 0, 1, 0, bit_of(3));
        issue_valid = 1; dst0(3); dst1(3); push("dedup_dst_r3", 0, 1, 0, 1, 0, bit_of(3));
        wb0(3); wb1(3);                    push("dual_wb_r3", 0, 0, 0, 1, 0, bit_of(3));
        push("r3_drained", 0, 0, 0, 0, 0, 32'h0);

        // VPU lock
        issue_valid = 1; vpu_start = 1;    push("vpu_launch", 0, 1, 0, 0, 0, 32'h0);
        issue_valid = 1; src0(17);         push("vpu_src17_stall", 1, 0, 1, 1, 0, 32'h0);
        issue_valid = 1; src0(2);          push("vpu_src2_ok", 0, 1, 1, 1, 0, 32'h0);
        issue_valid = 1; vpu_start = 1;    push("vpu_second_start", 1, 0, 1, 1, 0, 32'h0);
        issue_valid = 1; dst0(24);         push("vpu_window_top", 1, 0, 1, 1, 0, 32'h0);
        issue_valid = 1; src0(25);         push("vpu_above_window", 0, 1, 1, 1, 0, 32'h0);
        vpu_rdy = 1;                       push("vpu_rdy", 0, 0, 1, 1, 0, 32'h0);
        issue_valid = 1; vpu_start = 1; src0(17); push("vpu_relaunch", 0, 1, 0, 0, 0, 32'h0);
        vpu_rdy = 1;                       push("vpu_rdy2", 0, 0, 1, 1, 0, 32'h0);
        issue_valid = 1; vpu_start = 1; vpu_rdy = 1; push("vpu_start_and_rdy", 0, 1, 0, 0, 0, 32'h0);
        push("vpu_launch_wins", 0, 0, 1, 1, 0, 32'h0);
        vpu_rdy = 1;                       push("vpu_rdy3", 0, 0, 1, 1, 0, 32'h0);
        vpu_rdy = 1;                       push("vpu_rdy_unlocked", 0, 0, 0, 0, 0, 32'h0);
        push("vpu_still_unlocked", 0, 0, 0, 0, 0, 32'h0);

        // Underflow on r9
        wb0(9);                            push("uf_wb_r9", 0, 0, 0, 0, 0, 32'h0);
        push("uf_sticky1", 0, 0, 0, 0, 1, 32'h0);
        issue_valid = 1; src0(9);          push("uf_count_zero", 0, 1, 0, 0, 1, 32'h0);

        // Mid-operation reset
        issue_valid = 1; dst0(11); vpu_start = 1; push("rst_setup", 0, 1, 0, 0, 1, 32'h0);
        issue_valid = 1; src0(11);         push("rst_pre_stall", 1, 0, 1, 1, 1, bit_of(11));
        rst = 1; issue_valid = 1; src0(11); push("rst_asserted", 1, 0, 1, 1, 1, bit_of(11));
        issue_valid = 1; src0(11);         push("rst_after", 0, 1, 0, 0, 0, 32'h0);

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d leftover expectations, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got time %0t", $time);
        $fatal(1);
    end

endmodule
